// File: rtl/bs_rbtr_rr_bp_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : bs_rbtr_rr_bp_if
// Brief    : Driver-FIFO side bundle of the round-robin bus arbiter.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface bs_rbtr_rr_bp_if #(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 32,
    parameter int CNT_W   = 16
);
    logic [DRVRS-1:0]         pndng;
    logic [DRVRS*PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]         full;
    logic [DRVRS-1:0]         pop;
    logic [DRVRS-1:0]         push;
    logic [DRVRS*PCKG_SZ-1:0] D_push;
    logic                     busy;
    logic                     drop;
    logic [CNT_W-1:0]         msg_cnt;
    logic [CNT_W-1:0]         drop_cnt;

    modport master (
        input  pndng, D_pop, full,
        output pop, push, D_push, busy, drop, msg_cnt, drop_cnt
    );

    modport slave (
        output pndng, D_pop, full,
        input  pop, push, D_push, busy, drop, msg_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bs_rbtr_rr_bp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : bs_rbtr_rr_bp
// Brief    : Round-robin bus arbiter with destination backpressure, timeout
//            drop, invalid-target drop and saturating status counters.
// Revision : 1.0
// ----------------------------------------------------------------------------
module bs_rbtr_rr_bp #(
    parameter int                DRVRS     = 4,
    parameter int                PCKG_SZ   = 32,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BROADCAST = 8'hFF,
    parameter int                TIMEOUT   = 16,
    parameter int                CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    bs_rbtr_rr_bp_if.master         bus
);
    localparam int c_iw = $clog2(DRVRS);
    localparam int c_ww = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DRVRS-1:0] c_one = {{(DRVRS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_ROUTE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_iw-1:0]     r_rr_ptr;
    logic [c_iw-1:0]     r_grant;
    logic [c_iw-1:0]     w_scan_grant;
    logic                w_scan_hit;
    logic [PCKG_SZ-1:0]  r_pkt;
    logic [c_ww-1:0]     r_wait;
    logic [CNT_W-1:0]    r_msg_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic [ADDR_W-1:0]   w_target;
    logic                w_unicast;
    logic                w_bcast;
    logic                w_invalid;
    logic                w_blocked;
    logic                w_timeout;
    logic [DRVRS-1:0]    w_dst;
    logic                w_deliver;
    logic                w_discard;
    logic [c_iw-1:0]     w_rr_nxt;

    // Rotating priority scan starting at r_rr_ptr, wrapping modulo DRVRS.
    always_comb begin
        logic [c_iw:0] idx;
        w_scan_hit   = 1'b0;
        w_scan_grant = r_rr_ptr;
        idx          = '0;
        for (int k = 0; k < DRVRS; k++) begin
            idx = {1'b0, r_rr_ptr} + (c_iw+1)'(k);
            if (idx >= (c_iw+1)'(DRVRS)) begin
                idx = idx - (c_iw+1)'(DRVRS);
            end
            if (!w_scan_hit && bus.pndng[idx[c_iw-1:0]]) begin
                w_scan_hit   = 1'b1;
                w_scan_grant = idx[c_iw-1:0];
            end
        end
    end

    assign w_target  = r_pkt[PCKG_SZ-1 -: ADDR_W];
    assign w_unicast = (32'(w_target) < 32'(DRVRS));
    assign w_bcast   = !w_unicast && (w_target == BROADCAST);
    assign w_invalid = !w_unicast && !w_bcast;
    assign w_dst     = w_unicast ? (c_one << w_target) :
                       w_bcast   ? ~(c_one << r_grant) : '0;
    // Any full destination stalls the whole set, keeping broadcast atomic.
    assign w_blocked = |(w_dst & bus.full);
    assign w_timeout = (r_wait == c_ww'(TIMEOUT-1));
    assign w_deliver = (r_state == ST_ROUTE) && !w_invalid && !w_blocked;
    assign w_discard = (r_state == ST_ROUTE) && (w_invalid || (w_blocked && w_timeout));
    assign w_rr_nxt  = (r_grant == c_iw'(DRVRS-1)) ? '0 : r_grant + c_iw'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_scan_hit) w_state_nxt = ST_POP;
            ST_POP:   w_state_nxt = ST_ROUTE;
            ST_ROUTE: if (w_deliver || w_discard) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_pkt      <= '0;
            r_wait     <= '0;
            r_msg_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_scan_hit) r_grant <= w_scan_grant;
                end
                ST_POP: begin
                    r_pkt  <= bus.D_pop[r_grant*PCKG_SZ +: PCKG_SZ];
                    r_wait <= '0;
                end
                ST_ROUTE: begin
                    if (w_deliver || w_discard) r_rr_ptr <= w_rr_nxt;
                    else                        r_wait   <= r_wait + c_ww'(1);
                end
                default: ;
            endcase
            if (w_deliver && (r_msg_cnt != '1))  r_msg_cnt  <= r_msg_cnt + CNT_W'(1);
            if (w_discard && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    assign bus.pop      = (r_state == ST_POP) ? (c_one << r_grant) : '0;
    assign bus.push     = w_deliver ? w_dst : '0;
    assign bus.drop     = w_discard;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.D_push   = {DRVRS{r_pkt}};
    assign bus.msg_cnt  = r_msg_cnt;
    assign bus.drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
